// File: rtl/cu_engine.sv
// cu_engine: 3x3 sliding-window multiply-accumulate engine.
// A new image column enters the window every cycle. Nine processing
// elements multiply window pixels by filter weights, and a registered
// adder sums the products into a 16-bit result that wraps on overflow.
module cu_engine (
    input  logic        clk,
    input  logic        nrst,
    input  logic [71:0] filter,
    input  logic [23:0] data_in,
    input  logic [8:0]  pe_en_ctrl,
    output logic [15:0] pe_out
);

    localparam int ROWS = 3;
    localparam int COLS = 3;
    localparam int PES  = ROWS * COLS;

    // window[r][0] holds the newest column, window[r][2] the oldest
    logic [7:0]  window  [ROWS][COLS];
    logic [7:0]  weight  [PES];
    logic [15:0] product [PES];
    logic [17:0] row_sum [ROWS];
    logic [19:0] total_sum;

    // Shift the window by one column per clock; there is no stall
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    window[r][c] <= 8'h00;
                end
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                window[r][2] <= window[r][1];
                window[r][1] <= window[r][0];
                window[r][0] <= data_in[8*r +: 8];
            end
        end
    end

    // Unpack weights straight from the port; no copy of the filter is kept
    always_comb begin
        for (int k = 0; k < PES; k++) begin
            weight[k] = filter[8*k +: 8];
        end
    end

    // One registered unsigned multiplier per processing element
    for (genvar k = 0; k < PES; k++) begin : g_pe
        localparam int ROW = k / COLS;
        localparam int COL = k % COLS;

        // Disabled elements load exactly zero regardless of weight and pixel
        always_ff @(posedge clk or posedge nrst) begin
            if (nrst) begin
                product[k] <= 16'h0000;
            end else if (pe_en_ctrl[k]) begin
                product[k] <= {8'h00, weight[k]} * {8'h00, window[ROW][COL]};
            end else begin
                product[k] <= 16'h0000;
            end
        end
    end

    // Row partial sums then the total, widened so no carry is lost internally
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_sum[r] = {2'b00, product[3*r]}
                       + {2'b00, product[3*r + 1]}
                       + {2'b00, product[3*r + 2]};
        end
        total_sum = {2'b00, row_sum[0]} + {2'b00, row_sum[1]} + {2'b00, row_sum[2]};
    end

    // Register the result, keeping only the low 16 bits (modulo wrap)
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            pe_out <= 16'h0000;
        end else begin
            pe_out <= 16'(total_sum);
        end
    end

endmodule

// File: tb/tb_cu_engine.sv
// tb_cu_engine: directed and randomized checks of cu_engine against a
// reference model that recomputes each result from the history of
// columns, weights and enables applied since the last reset.
module tb_cu_engine;

    localparam int HIST = 1024;

    logic        clk;
    logic        nrst;
    logic [71:0] filter;
    logic [23:0] data_in;
    logic [8:0]  pe_en_ctrl;
    logic [15:0] pe_out;

    int checks;
    int errors;
    int edge_idx;

    logic [23:0] col_hist [HIST];
    logic [71:0] fil_hist [HIST];
    logic [8:0]  en_hist  [HIST];

    cu_engine dut (
        .clk        (clk),
        .nrst       (nrst),
        .filter     (filter),
        .data_in    (data_in),
        .pe_en_ctrl (pe_en_ctrl),
        .pe_out     (pe_out)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against the run never finishing
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value with its expected value and count it
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, observed, expected);
        end
    endtask

    // Expected pe_out after edge e (counted from 0 after reset release):
    // weights/enables are those present at edge e-1, and the pixel in
    // window column c is the column applied at edge e-2-c.
    function automatic logic [15:0] modelOut(input int e);
        int sum;
        int src;
        logic [7:0] w;
        logic [7:0] px;
        sum = 0;
        if (e >= 1) begin
            for (int k = 0; k < 9; k++) begin
                src = e - 2 - (k % 3);
                if (en_hist[e-1][k] && src >= 0) begin
                    w   = fil_hist[e-1][8*k +: 8];
                    px  = col_hist[src][8*(k/3) +: 8];
                    sum = sum + int'(w) * int'(px);
                end
            end
        end
        return 16'(sum % 65536);
    endfunction

    // Drive one cycle of inputs, record them, and advance past the edge
    task automatic applyStimulus(input logic [71:0] f, input logic [23:0] d,
                                 input logic [8:0] en);
        filter     = f;
        data_in    = d;
        pe_en_ctrl = en;
        col_hist[edge_idx] = d;
        fil_hist[edge_idx] = f;
        en_hist[edge_idx]  = en;
        @(posedge clk);
        #1;
        edge_idx++;
    endtask

    // Assert reset with toggling inputs, then release between edges
    task automatic applyReset(input int cycles);
        nrst = 1'b1;
        #1;
        checkOutput("rst_async", pe_out, 16'h0000);
        for (int i = 0; i < cycles; i++) begin
            filter     = {$urandom, $urandom, $urandom};
            data_in    = 24'($urandom);
            pe_en_ctrl = 9'($urandom);
            @(posedge clk);
            #1;
            checkOutput("rst_hold", pe_out, 16'h0000);
        end
        nrst     = 1'b0;
        edge_idx = 0;
    endtask

    logic [15:0] exp_full  [6];
    logic [15:0] exp_row0  [6];
    logic [71:0] rand_filter;
    logic [8:0]  rand_en;
    int          sel;

    initial begin
        checks     = 0;
        errors     = 0;
        edge_idx   = 0;
        nrst       = 1'b1;
        filter     = '0;
        data_in    = '0;
        pe_en_ctrl = '0;
        exp_full   = '{16'd0, 16'd0, 16'd6, 16'd12, 16'd18, 16'd18};
        exp_row0   = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd3};

        applyReset(4);

        // Uniform weights of one, all elements on
        for (int i = 0; i < 6; i++) begin
            applyStimulus({9{8'h01}}, 24'h030201, 9'h1FF);
            checkOutput("full_win", pe_out, exp_full[i]);
        end

        applyReset(2);
        // Only row 0 elements enabled
        for (int i = 0; i < 6; i++) begin
            applyStimulus({9{8'h01}}, 24'h030201, 9'b000000111);
            checkOutput("row0_en", pe_out, exp_row0[i]);
        end

        applyReset(2);
        // Diagonal filter picks x[0][0], x[1][1], x[2][2]
        applyStimulus(72'h010000000100000001, 24'h020100, 9'h1FF);
        applyStimulus(72'h010000000100000001, 24'h0A0908, 9'h1FF);
        applyStimulus(72'h010000000100000001, 24'h1211FF, 9'h1FF);
        applyStimulus(72'h010000000100000001, 24'h000000, 9'h1FF);
        checkOutput("diag_part", pe_out, 16'h0009);
        applyStimulus(72'h010000000100000001, 24'h000000, 9'h1FF);
        checkOutput("diag_full", pe_out, 16'h010A);

        applyReset(2);
        // Maximum operands wrap modulo 2^16
        for (int i = 0; i < 5; i++) begin
            applyStimulus({9{8'hFF}}, 24'hFFFFFF, 9'h1FF);
        end
        checkOutput("wrap", pe_out, 16'hEE09);
        // Enables drop: result falls one edge after products see zero enables
        applyStimulus({9{8'hFF}}, 24'hFFFFFF, 9'h000);
        checkOutput("en_drop_n", pe_out, 16'hEE09);
        applyStimulus({9{8'hFF}}, 24'hFFFFFF, 9'h000);
        checkOutput("en_drop_n1", pe_out, 16'h0000);

        // Randomized traffic, with a mid-stream reset after each block
        for (int blk = 0; blk < 3; blk++) begin
            applyReset(2);
            rand_filter = {$urandom, $urandom, $urandom};
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    rand_filter = {$urandom, $urandom, $urandom};
                end
                sel = int'($urandom_range(0, 5));
                if (sel == 0) begin
                    rand_en = 9'h1FF;
                end else if (sel == 1) begin
                    rand_en = 9'h000;
                end else begin
                    rand_en = 9'($urandom);
                end
                applyStimulus(rand_filter, 24'($urandom), rand_en);
                checkOutput("random", pe_out, modelOut(edge_idx - 1));
            end
        end

        // Async reset lands between edges on a loaded pipeline
        applyReset(0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus({9{8'hFF}}, 24'hFFFFFF, 9'h1FF);
        end
        #3;
        nrst = 1'b1;
        #1;
        checkOutput("rst_mid", pe_out, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("rst_mid_hold", pe_out, 16'h0000);
        nrst     = 1'b0;
        edge_idx = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus({9{8'h02}}, 24'h010101, 9'h1FF);
            checkOutput("post_rst", pe_out, modelOut(edge_idx - 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
